pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Controller that sequences the pc address-table block.
- Streams a program image into the table through a valid/ready load port, then drives table reads for instruction fetch.
- Fetch order is sequential, with branch redirect, stall and halt.
- Sits between the host/boot loader, the core pipeline control and the pc table; it is the only driver of the table's instr_en/pc_adr/en/in inputs.

Parameters:
MEM_LENGTH, 256, table depth in words; max program length.
IDX_W, 8, index width; log2(MEM_LENGTH).
DATA_W, 32, table word width.

Ports:
clk  input  1  clock, rising edge.
res  input  1  synchronous reset, active-high.
ld_start  input  1  open a load session.
ld_valid  input  1  load word valid.
ld_data  input  DATA_W  load word.
ld_last  input  1  final word of image; qualified by the handshake.
ld_ready  output  1  controller accepts a load word.
run_start  input  1  begin or restart fetch at index 0.
stall  input  1  hold the current fetch index.
br_taken  input  1  redirect fetch.
br_idx  input  IDX_W  redirect target index.
halt_req  input  1  stop fetching.
pc_instr_en  output  1  table write strobe.
pc_adr  output  DATA_W  table write data.
pc_en  output  1  table read enable.
pc_in  output  IDX_W  table read index.
load_count  output  IDX_W+1  words loaded so far.
state_o  output  2  IDLE=0, LOAD=1, RUN=2, HALT=3.
err  output  1  sticky error flag.

Behaviour:
- Reset:
  - res sampled at a rising edge.
  - State becomes IDLE.
  - All outputs cleared: pc_instr_en, pc_adr, pc_en, pc_in, load_count, err, ld_ready are 0.
  - res overrides every other input and works mid-load and mid-run.
- Registering and latency:
  - All outputs are registered.
  - ld_ready is a registered function of state and load_count.
  - A load handshake (ld_valid & ld_ready) at edge N gives pc_instr_en=1 and pc_adr=ld_data in cycle N+1, for exactly 1 cycle per word.
  - load_count increments at the same edge as the handshake.
- IDLE:
  - ld_start with load_count==0 goes to LOAD.
  - ld_start with load_count!=0 is ignored and sets err. The table's write pointer clears only on table reset, so appending is illegal.
  - run_start with load_count>0 goes to RUN with fetch index 0.
  - run_start with load_count==0 is ignored.
  - ld_start has priority over run_start.
- LOAD:
  - ld_ready=1 while load_count<MEM_LENGTH.
  - A handshake with ld_last=1 goes to IDLE.
  - The handshake that brings load_count to MEM_LENGTH goes to IDLE, with ld_ready=0 from the next cycle.
  - ld_valid=0 holds the state; no timeout.
  - run_start is ignored in LOAD.
- RUN: each cycle, first matching rule wins.
  1. halt_req: HALT; pc_en=0 next cycle.
  2. stall: pc_en=0, pc_in held, branch ignored.
  3. br_taken with br_idx>=load_count: err=1, HALT.
  4. br_taken: pc_en=1, pc_in=br_idx.
  5. Otherwise: pc_en=1, pc_in=current index; index increments.
- RUN end of program:
  - Fetch of index load_count-1 without a branch: that fetch is issued, then state goes to HALT.
  - There is no wrap-around.
- Fetch latency: the table output is valid 2 cycles after the decision edge (this controller's register, then the table register).
- Invariant: pc_instr_en and pc_en are never 1 in the same cycle.
- HALT:
  - pc_en=0 and pc_instr_en=0.
  - run_start restarts RUN at index 0.
  - ld_start is ignored and sets err.
- Width rules:
  - Index arithmetic is modulo 2^IDX_W.
  - load_count is IDX_W+1 bits so that MEM_LENGTH is representable.
  - err clears only on res.

Optional Feature:
- Macro: PC_LOAD_CSUM_EN.
- When defined:
  - Adds output load_csum [DATA_W-1:0].
  - On each load handshake: load_csum <= rotate-left-1(load_csum) XOR ld_data.
  - Cleared on res and on LOAD entry.
  - Held otherwise.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Load after reset: res 1 cycle, ld_start, 3 words 0x10/0x20/0x30 (last flagged) → pc_instr_en pulses in 3 cycles, pc_adr matches; load_count=3; state IDLE.
- Sequential run: run_start, no stall → pc_in=0,1,2 on consecutive cycles with pc_en=1; state HALT after index 2; err=0.
- Stall and branch priority: load 8 words; stall for 2 cycles at index 3 with br_taken=1, br_idx=6 → pc_in holds 3, pc_en=0; release with br_taken, br_idx=6 → pc_in=6, then 7, then HALT.
- Boundary errors:
  - Branch to br_idx=9 with load_count=8 → err=1, HALT.
  - A second ld_start → err stays 1, state unchanged.
- Full table: stream 256 words without ld_last → ld_ready=0 after the 256th; load_count=256; IDLE; 257th ld_valid is not accepted.
- Reset mid-run and checksum:
  - res during RUN → all outputs 0 next cycle.
  - With PC_LOAD_CSUM_EN and words 0x1, 0x2 → load_csum=0x0.
  - With PC_LOAD_CSUM_EN and words 0x1, 0x3 → load_csum=0x1.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Load/fetch sequencer for the pc address table: streams an image in, then issues table reads.
// Optional macro PC_LOAD_CSUM_EN adds the load_csum output (rotate-xor checksum of the loaded image).
module pc_fetch_ctrl #(
  parameter int MEM_LENGTH = 256,
  parameter int IDX_W      = 8,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              run_start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [IDX_W-1:0]  br_idx,
  input  logic              halt_req,
  output logic              pc_instr_en,
  output logic [DATA_W-1:0] pc_adr,
  output logic              pc_en,
  output logic [IDX_W-1:0]  pc_in,
  output logic [IDX_W:0]    load_count,
  output logic [1:0]        state_o,
  output logic              err
`ifdef PC_LOAD_CSUM_EN
  ,
  output logic [DATA_W-1:0] load_csum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [IDX_W:0]   MAX_COUNT = (IDX_W+1)'(MEM_LENGTH);
  localparam logic [IDX_W:0]   COUNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_t              state, state_n;
  logic [IDX_W:0]      count_n, last_idx;
  logic [IDX_W-1:0]    idx, idx_n, pc_in_n;
  logic [DATA_W-1:0]   pc_adr_n;
  logic                pc_en_n, instr_en_n, err_n, ld_ready_n;
  logic                handshake, br_oob;

  assign state_o   = state;
  assign handshake = ld_valid & ld_ready;
  assign last_idx  = load_count - COUNT_ONE;
  assign br_oob    = {1'b0, br_idx} >= load_count;

  always_comb begin
    state_n    = state;
    count_n    = load_count;
    idx_n      = idx;
    pc_in_n    = pc_in;
    pc_adr_n   = pc_adr;
    pc_en_n    = 1'b0;
    instr_en_n = 1'b0;
    err_n      = err;
    case (state)
      IDLE: begin
        // Appending to a non-empty table is illegal: the table pointer only clears on its own reset.
        if (ld_start) begin
          if (load_count == '0) state_n = LOAD;
          else                  err_n   = 1'b1;
        end else if (run_start && load_count != '0) begin
          state_n = RUN;
          idx_n   = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          instr_en_n = 1'b1;
          pc_adr_n   = ld_data;
          count_n    = load_count + COUNT_ONE;
          if (ld_last || count_n == MAX_COUNT) state_n = IDLE;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_n = HALT;
        end else if (!stall) begin
          if (br_taken && br_oob) begin
            err_n   = 1'b1;
            state_n = HALT;
          end else begin
            // Any fetch of the final loaded word ends the program; there is no wrap-around.
            pc_en_n = 1'b1;
            pc_in_n = br_taken ? br_idx : idx;
            idx_n   = pc_in_n + IDX_ONE;
            if ({1'b0, pc_in_n} == last_idx) state_n = HALT;
          end
        end
      end
      HALT: begin
        if (ld_start) begin
          err_n = 1'b1;
        end else if (run_start) begin
          state_n = RUN;
          idx_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    ld_ready_n = (state_n == LOAD) && (count_n < MAX_COUNT);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      load_count  <= '0;
      idx         <= '0;
      pc_instr_en <= 1'b0;
      pc_adr      <= '0;
      pc_en       <= 1'b0;
      pc_in       <= '0;
      err         <= 1'b0;
      ld_ready    <= 1'b0;
    end else begin
      state       <= state_n;
      load_count  <= count_n;
      idx         <= idx_n;
      pc_instr_en <= instr_en_n;
      pc_adr      <= pc_adr_n;
      pc_en       <= pc_en_n;
      pc_in       <= pc_in_n;
      err         <= err_n;
      ld_ready    <= ld_ready_n;
    end
  end

`ifdef PC_LOAD_CSUM_EN
  always_ff @(posedge clk) begin
    if (res) begin
      load_csum <= '0;
    end else if (state == IDLE && ld_start && load_count == '0) begin
      load_csum <= '0;
    end else if (handshake) begin
      load_csum <= {load_csum[DATA_W-2:0], load_csum[DATA_W-1]} ^ ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based program model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        res, ld_start, ld_valid, ld_last, run_start, stall, br_taken, halt_req;
  logic [31:0] ld_data;
  logic [7:0]  br_idx;
  logic        ld_ready, pc_instr_en, pc_en, err;
  logic [31:0] pc_adr;
  logic [7:0]  pc_in;
  logic [8:0]  load_count;
  logic [1:0]  state_o;
`ifdef PC_LOAD_CSUM_EN
  logic [31:0] load_csum;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model: loaded image as a queue, fetch cursor as an int; modes 0 idle, 1 load, 2 run, 3 halt.
  logic [31:0] loaded[$];
  int   m_mode, m_next, m_in;
  logic m_en, m_instr, m_ready, m_err;

  pc_fetch_ctrl dut (
    .clk(clk), .res(res), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .run_start(run_start), .stall(stall),
    .br_taken(br_taken), .br_idx(br_idx), .halt_req(halt_req), .pc_instr_en(pc_instr_en),
    .pc_adr(pc_adr), .pc_en(pc_en), .pc_in(pc_in), .load_count(load_count),
    .state_o(state_o), .err(err)
`ifdef PC_LOAD_CSUM_EN
    , .load_csum(load_csum)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef PC_LOAD_CSUM_EN
  function automatic logic [31:0] fold_csum();
    logic [31:0] c = '0;
    foreach (loaded[i]) c = {c[30:0], c[31]} ^ loaded[i];
    return c;
  endfunction
`endif

  always @(posedge clk) begin
    int sz, f;
    if (res) begin
      m_mode = 0; loaded.delete(); m_next = 0; m_in = 0;
      m_en = 0; m_instr = 0; m_err = 0; m_ready = 0;
      chk_on = 1'b1;
    end else if (chk_on) begin
      sz = loaded.size();
      m_en = 0;
      m_instr = 0;
      case (m_mode)
        0: begin
          if (ld_start) begin
            if (sz == 0) m_mode = 1;
            else m_err = 1;
          end else if (run_start && sz > 0) begin
            m_mode = 2; m_next = 0;
          end
        end
        1: begin
          if (ld_valid && m_ready) begin
            loaded.push_back(ld_data);
            m_instr = 1;
            if (ld_last || loaded.size() == 256) m_mode = 0;
          end
        end
        2: begin
          if (halt_req) m_mode = 3;
          else if (!stall) begin
            if (br_taken && int'(br_idx) >= sz) begin
              m_err = 1; m_mode = 3;
            end else begin
              f = br_taken ? int'(br_idx) : m_next;
              m_en = 1; m_in = f; m_next = f + 1;
              if (f == sz - 1) m_mode = 3;
            end
          end
        end
        default: begin
          if (ld_start) m_err = 1;
          else if (run_start) begin
            m_mode = 2; m_next = 0;
          end
        end
      endcase
      m_ready = (m_mode == 1) && (loaded.size() < 256);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("state", 64'(state_o), 64'(m_mode));
      checkOutput("ld_ready", 64'(ld_ready), 64'(m_ready));
      checkOutput("pc_instr_en", 64'(pc_instr_en), 64'(m_instr));
      checkOutput("pc_adr", 64'(pc_adr), 64'(loaded.size() > 0 ? loaded[loaded.size()-1] : 32'h0));
      checkOutput("pc_en", 64'(pc_en), 64'(m_en));
      checkOutput("pc_in", 64'(pc_in), 64'(m_in));
      checkOutput("load_count", 64'(load_count), 64'(loaded.size()));
      checkOutput("err", 64'(err), 64'(m_err));
      checkOutput("en_exclusive", 64'(pc_en & pc_instr_en), 64'(0));
`ifdef PC_LOAD_CSUM_EN
      checkOutput("load_csum", 64'(load_csum), 64'(fold_csum()));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    res = 0; ld_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
    run_start = 0; stall = 0; br_taken = 0; br_idx = '0; halt_req = 0;
  endtask

  task automatic do_reset();
    res = 1;
    tick();
    res = 0;
  endtask

  task automatic load_words(input int n, input logic [31:0] base, input logic flag_last);
    ld_start = 1;
    tick();
    ld_start = 0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1;
      ld_data  = base + 32'(i);
      ld_last  = flag_last && (i == n - 1);
      tick();
    end
    ld_valid = 0;
    ld_last  = 0;
  endtask

  task automatic applyStimulus();
    int sz;
    sz = loaded.size();
    res = ($urandom_range(0, 249) == 0);
    ld_start = 0;
    run_start = 0;
    case (m_mode)
      0: begin
        ld_start  = ($urandom_range(0, 5) == 0);
        run_start = ($urandom_range(0, 2) == 0);
      end
      1: run_start = ($urandom_range(0, 3) == 0);
      3: begin
        if ($urandom_range(0, 9) == 0) ld_start = 1;
        else run_start = ($urandom_range(0, 3) == 0);
      end
      default: ;
    endcase
    ld_valid = ($urandom_range(0, 9) < 7);
    ld_data  = $urandom;
    ld_last  = ($urandom_range(0, 7) == 0);
    stall    = ($urandom_range(0, 5) == 0);
    halt_req = ($urandom_range(0, 39) == 0);
    br_taken = ($urandom_range(0, 4) == 0);
    if (sz >= 2 && $urandom_range(0, 3) != 0) br_idx = 8'($urandom_range(0, sz - 2));
    else if (sz < 256) br_idx = 8'($urandom_range(sz, 255));
    else br_idx = 8'($urandom_range(0, 254));
  endtask

  initial begin
    idle_inputs();
    res = 1;
    tick();
    checkOutput("rst_state", 64'(state_o), 64'(0));
    checkOutput("rst_ld_ready", 64'(ld_ready), 64'(0));
    checkOutput("rst_count", 64'(load_count), 64'(0));
    checkOutput("rst_pc_en", 64'(pc_en), 64'(0));
    res = 0;

    // Three-word image, last word flagged.
    ld_start = 1;
    tick();
    checkOutput("load_state", 64'(state_o), 64'(1));
    checkOutput("load_ready", 64'(ld_ready), 64'(1));
    ld_start = 0;
    for (int i = 1; i <= 3; i++) begin
      ld_valid = 1;
      ld_data  = 32'(i * 16);
      ld_last  = (i == 3);
      tick();
      checkOutput("load_wr_en", 64'(pc_instr_en), 64'(1));
      checkOutput("load_wr_data", 64'(pc_adr), 64'(i * 16));
    end
    ld_valid = 0; ld_last = 0;
    checkOutput("load3_count", 64'(load_count), 64'(3));
    checkOutput("load3_state", 64'(state_o), 64'(0));
    checkOutput("load3_ready", 64'(ld_ready), 64'(0));

    // Sequential run 0,1,2 then halt.
    run_start = 1;
    tick();
    checkOutput("run_state", 64'(state_o), 64'(2));
    checkOutput("run_wr_off", 64'(pc_instr_en), 64'(0));
    run_start = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("seq_pc_en", 64'(pc_en), 64'(1));
      checkOutput("seq_pc_in", 64'(pc_in), 64'(i));
    end
    checkOutput("seq_end_state", 64'(state_o), 64'(3));
    tick();
    checkOutput("halt_pc_en", 64'(pc_en), 64'(0));
    checkOutput("halt_err", 64'(err), 64'(0));

    // Stall beats branch; then branch to 6, fetch 7, halt.
    do_reset();
    load_words(8, 32'h100, 1'b1);
    run_start = 1;
    tick();
    run_start = 0;
    repeat (4) tick();
    checkOutput("pre_stall_in", 64'(pc_in), 64'(3));
    stall = 1; br_taken = 1; br_idx = 8'd6;
    repeat (2) begin
      tick();
      checkOutput("stall_pc_en", 64'(pc_en), 64'(0));
      checkOutput("stall_pc_in", 64'(pc_in), 64'(3));
    end
    stall = 0;
    tick();
    checkOutput("br_pc_in", 64'(pc_in), 64'(6));
    checkOutput("br_pc_en", 64'(pc_en), 64'(1));
    br_taken = 0;
    tick();
    checkOutput("after_br_in", 64'(pc_in), 64'(7));
    checkOutput("after_br_state", 64'(state_o), 64'(3));

    // Out-of-range branch, then illegal ld_start from HALT.
    run_start = 1;
    tick();
    run_start = 0; br_taken = 1; br_idx = 8'd9;
    tick();
    checkOutput("oob_err", 64'(err), 64'(1));
    checkOutput("oob_state", 64'(state_o), 64'(3));
    br_taken = 0; ld_start = 1;
    tick();
    ld_start = 0;
    checkOutput("reld_err", 64'(err), 64'(1));
    checkOutput("reld_state", 64'(state_o), 64'(3));

    // Full table without ld_last.
    do_reset();
    load_words(256, 32'h0, 1'b0);
    checkOutput("full_ready", 64'(ld_ready), 64'(0));
    checkOutput("full_count", 64'(load_count), 64'(256));
    checkOutput("full_state", 64'(state_o), 64'(0));
    ld_valid = 1; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_valid = 0;
    checkOutput("over_wr_en", 64'(pc_instr_en), 64'(0));
    checkOutput("over_count", 64'(load_count), 64'(256));

    // Reset during RUN.
    run_start = 1;
    tick();
    run_start = 0;
    repeat (2) tick();
    res = 1;
    tick();
    res = 0;
    checkOutput("midrun_rst_state", 64'(state_o), 64'(0));
    checkOutput("midrun_rst_pc_en", 64'(pc_en), 64'(0));
    checkOutput("midrun_rst_pc_in", 64'(pc_in), 64'(0));
    checkOutput("midrun_rst_count", 64'(load_count), 64'(0));

`ifdef PC_LOAD_CSUM_EN
    load_words(2, 32'h1, 1'b1);
    checkOutput("csum_1_2", 64'(load_csum), 64'(0));
    do_reset();
    ld_start = 1;
    tick();
    ld_start = 0; ld_valid = 1; ld_data = 32'h1;
    tick();
    ld_data = 32'h3; ld_last = 1;
    tick();
    ld_valid = 0; ld_last = 0;
    checkOutput("csum_1_3", 64'(load_csum), 64'(1));
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
